// File: rtl/lamp_pkg.sv
// Shared constants, state encoding and time-word helper for the LED-chain frame receiver.
package lamp_pkg;

    localparam int c_words_per_board = 32;
    localparam int c_bpc             = 12;
    localparam int c_max_time        = 1024;
    localparam int c_time_w          = $clog2(c_max_time);

    typedef enum logic [1:0] {
        st_hdr  = 2'd0,
        st_data = 2'd1,
        st_ovf  = 2'd2
    } rx_state_t;

    function automatic int channels(input int ledboards);
        return ledboards * c_words_per_board;
    endfunction

    // Out-of-range time words clamp to the longest transition instead of wrapping.
    function automatic logic [c_time_w-1:0] sat_time(input logic [c_bpc-1:0] w);
        if (|w[c_bpc-1:c_time_w])
            return c_time_w'(c_max_time - 1);
        else
            return w[c_time_w-1:0];
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous host line, plus a rising-edge pulse on the synced value.
module sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic [2:0] sync_sr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            sync_sr <= '0;
        else
            sync_sr <= {sync_sr[1:0], i_d};
    end

    assign o_rise = sync_sr[1] & ~sync_sr[2];

endmodule

// File: rtl/frame_rx.sv
// Serial frame receiver: deserialises a time word plus one word per channel and writes
// channels into the framebuffer in chain order; a latch edge commits or rejects the frame.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   st_hdr  | shifting the time word
//   st_data | shifting channel words, each completed word is written out
//   st_ovf  | more words than channels; ignore bits until latch
module frame_rx
    import lamp_pkg::*;
#(
    parameter  int c_ledboards = 30,
    localparam int c_channels  = channels(c_ledboards),
    localparam int c_addr_w    = $clog2(c_channels)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_sclk,
    input  logic                i_sdi,
    input  logic                i_lat,
    output logic                o_wen,
    output logic [c_addr_w-1:0] o_waddr,
    output logic [c_bpc-1:0]    o_wdata,
    output logic [c_time_w-1:0] o_time,
    output logic                o_frame_done,
    output logic                o_err
);

    localparam int c_bit_w  = $clog2(c_bpc);
    localparam int c_word_w = $clog2(c_channels + 3);

    logic                sclk_rise;
    logic                lat_rise;
    logic [1:0]          sdi_sync;
    logic [c_bpc-2:0]    shift_reg;
    logic [c_bpc-1:0]    word_next;
    logic [c_bit_w-1:0]  bit_cnt;
    logic [c_word_w-1:0] word_cnt;
    logic [c_time_w-1:0] time_hold;
    logic                last_bit;
    rx_state_t           state;

    sync_edge u_sync_sclk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_sclk),
        .o_rise  (sclk_rise)
    );

    sync_edge u_sync_lat (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_lat),
        .o_rise  (lat_rise)
    );

    // sdi is tapped at the same depth as the sclk edge detector so each edge sees its own bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            sdi_sync <= '0;
        else
            sdi_sync <= {sdi_sync[0], i_sdi};
    end

    assign word_next = {shift_reg, sdi_sync[1]};
    assign last_bit  = (bit_cnt == c_bit_w'(c_bpc - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= st_hdr;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            time_hold    <= '0;
            o_wen        <= 1'b0;
            o_waddr      <= '0;
            o_wdata      <= '0;
            o_time       <= '0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_wen        <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
            // Latch takes priority; a coincident sclk edge is dropped.
            if (lat_rise) begin
                if (word_cnt == c_word_w'(c_channels + 1) && bit_cnt == '0) begin
                    o_time       <= time_hold;
                    o_frame_done <= 1'b1;
                end else begin
                    o_err <= 1'b1;
                end
                bit_cnt  <= '0;
                word_cnt <= '0;
                state    <= st_hdr;
            end else if (sclk_rise && state != st_ovf) begin
                shift_reg <= word_next[c_bpc-2:0];
                if (last_bit) begin
                    bit_cnt  <= '0;
                    word_cnt <= word_cnt + 1'b1;
                    case (state)
                        st_hdr: begin
                            time_hold <= sat_time(word_next);
                            state     <= st_data;
                        end
                        st_data: begin
                            if (word_cnt == c_word_w'(c_channels + 1)) begin
                                state <= st_ovf;
                            end else begin
                                o_wen   <= 1'b1;
                                o_waddr <= c_addr_w'(c_channels - int'(word_cnt));
                                o_wdata <= word_next;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_rx.sv
// Bench for frame_rx with one LED board (32 channels) and a host serial clock at i_clk/8.
module tb_frame_rx;

    localparam int c_ch = 32;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_sclk = 1'b0;
    logic        i_sdi = 1'b0;
    logic        i_lat = 1'b0;
    logic        o_wen;
    logic [4:0]  o_waddr;
    logic [11:0] o_wdata;
    logic [9:0]  o_time;
    logic        o_frame_done;
    logic        o_err;

    always #5 i_clk = ~i_clk;

    frame_rx #(.c_ledboards(1)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_sclk       (i_sclk),
        .i_sdi        (i_sdi),
        .i_lat        (i_lat),
        .o_wen        (o_wen),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata),
        .o_time       (o_time),
        .o_frame_done (o_frame_done),
        .o_err        (o_err)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [11:0] data;
    } wr_t;

    typedef struct {
        logic [11:0] tw;
        int          nwords;
        int          extra;
        logic [11:0] base;
        int          exp_done;
        int          exp_err;
        int          exp_time;
        int          exp_wr;
    } vec_t;

    int          checks = 0;
    int          fails = 0;
    int          n_wr = 0;
    int          n_done = 0;
    int          n_err = 0;
    wr_t         exp_q[$];
    logic [11:0] fb [c_ch];
    vec_t        vecs [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        wr_t e;
        if (i_rst_n) begin
            if (o_wen) begin
                n_wr++;
                fb[o_waddr] = o_wdata;
                if (exp_q.size() == 0) begin
                    check("write queue occupancy", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("waddr", int'(o_waddr), int'(e.addr));
                    check("wdata", int'(o_wdata), int'(e.data));
                end
            end
            if (o_frame_done) n_done++;
            if (o_err) n_err++;
            if (int'(o_wen) + int'(o_frame_done) + int'(o_err) > 1)
                check("pulse overlap", int'(o_wen) + int'(o_frame_done) + int'(o_err), 1);
        end
    end

    task automatic send_bits(input logic [11:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            i_sclk = 1'b0;
            i_sdi  = v[i];
            #40;
            i_sclk = 1'b1;
            #40;
        end
    endtask

    task automatic send_words(input logic [11:0] tw, input int nwords, input logic [11:0] base);
        logic [11:0] d;
        send_bits(tw, 12);
        for (int k = 1; k <= nwords; k++) begin
            d = base + 12'(k - 1);
            if (k <= c_ch) exp_q.push_back({5'(c_ch - k), d});
            send_bits(d, 12);
        end
    endtask

    task automatic pulse_latch();
        i_lat = 1'b1;
        #40;
        i_lat = 1'b0;
        #100;
    endtask

    task automatic clear_counts();
        n_wr   = 0;
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " o_wen"}, int'(o_wen), 0);
        check({tag, " o_waddr"}, int'(o_waddr), 0);
        check({tag, " o_wdata"}, int'(o_wdata), 0);
        check({tag, " o_time"}, int'(o_time), 0);
        check({tag, " o_frame_done"}, int'(o_frame_done), 0);
        check({tag, " o_err"}, int'(o_err), 0);
    endtask

    task automatic check_frame(input string tag, input int d, input int er, input int t, input int w);
        check({tag, " frame_done pulses"}, n_done, d);
        check({tag, " err pulses"}, n_err, er);
        check({tag, " o_time"}, int'(o_time), t);
        check({tag, " writes"}, n_wr, w);
        check({tag, " pending writes"}, exp_q.size(), 0);
    endtask

    initial begin
        //        tw       nw  extra base     done err time  wr
        vecs[0] = '{12'h064, 32, 0, 12'h000, 1, 0, 100,  32};
        vecs[1] = '{12'h123, 31, 0, 12'h100, 0, 1, 100,  31};
        vecs[2] = '{12'h010, 33, 0, 12'h200, 0, 1, 100,  32};
        vecs[3] = '{12'h050, 32, 5, 12'h300, 0, 1, 100,  32};
        vecs[4] = '{12'h007, 32, 0, 12'h400, 1, 0, 7,    32};
        vecs[5] = '{12'hFFF, 32, 0, 12'hABC, 1, 0, 1023, 32};
        vecs[6] = '{12'h200, 32, 0, 12'hF00, 1, 0, 512,  32};

        #23;
        check_reset_outputs("reset");
        i_rst_n = 1'b1;
        #50;

        for (int v = 0; v < 7; v++) begin
            clear_counts();
            send_words(vecs[v].tw, vecs[v].nwords, vecs[v].base);
            if (vecs[v].extra > 0) send_bits(12'h015, vecs[v].extra);
            #80;
            pulse_latch();
            check_frame($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err,
                        vecs[v].exp_time, vecs[v].exp_wr);
            if (v == 0) begin
                check("fb[31] first channel", int'(fb[31]), 0);
                check("fb[0] last channel", int'(fb[0]), 'h1F);
            end
        end

        // Reset in the middle of a frame, then a normal frame.
        clear_counts();
        send_words(12'h055, 10, 12'h010);
        #200;
        check("pre-reset writes", n_wr, 10);
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        i_sclk = 1'b0;
        i_sdi  = 1'b0;
        #40;
        i_rst_n = 1'b1;
        #50;
        clear_counts();
        send_words(12'h0C8, 32, 12'h020);
        #80;
        pulse_latch();
        check_frame("after reset", 1, 0, 200, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
